// File: rtl/rv_rf_pkg.sv
// Shared definitions for the multi-port register file with scoreboard.
// Holds the default geometry and the clear-sequencer state encoding.
package rv_rf_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;

   typedef enum logic [0:0] {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard.
//   clk, rst  : clock, async active-high reset (clears all pending bits)
//   wb_clr    : accepted writeback, clears bit wb_addr
//   iss_set   : accepted issue, sets bit iss_addr (wins over wb_clr)
//   seq_clr   : clear sequencer active, clears bit seq_idx
//   sb_post   : combinational view after writeback/sequencer clear,
//               before this cycle's issue set (used by the read ports)
module rf_scoreboard
   import rv_rf_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_clr,
   input  logic [AW-1:0]   wb_addr,
   input  logic            iss_set,
   input  logic [AW-1:0]   iss_addr,
   input  logic            seq_clr,
   input  logic [AW-1:0]   seq_idx,
   output logic [NREG-1:0] sb_post
);

   logic [NREG-1:0] sb_q;
   logic [NREG-1:0] sb_next;

   always_comb begin
      sb_post = sb_q;
      if (wb_clr) sb_post[wb_addr] = 1'b0;
      if (seq_clr) sb_post[seq_idx] = 1'b0;
      // Issue is applied last so a same-cycle write does not hide a new producer.
      sb_next = sb_post;
      if (iss_set) sb_next[iss_addr] = 1'b1;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sb_q <= '0;
      else     sb_q <= sb_next;
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-first bypass, pending-write
// scoreboard and a multi-cycle architectural clear sequencer. x0 reads zero.
//   clk, rst          : clock, async active-high reset
//   rd_en/rd_addr     : NRD read ports, address p at [p*AW +: AW]
//   rd_data/rd_pend   : registered read data / pending flag per port
//   wb_en/addr/data   : single writeback port
//   iss_en/iss_addr   : marks a destination as having an outstanding producer
//   clr_req/clr_busy  : start pulse / busy flag of the clear sequencer
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RF_IDLE  | normal operation; writes, issues and clr_req accepted
// RF_CLEAR | zeroing entry idx each cycle (1..NREG-1); wb/iss/clr ignored
module regfile_mp_sb
   import rv_rf_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int AW   = $clog2(NREG),
   parameter int NRD  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NRD-1:0]     rd_en,
   input  logic [NRD*AW-1:0]  rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]     rd_pend,
   input  logic               wb_en,
   input  logic [AW-1:0]      wb_addr,
   input  logic [XLEN-1:0]    wb_data,
   input  logic               iss_en,
   input  logic [AW-1:0]      iss_addr,
   input  logic               clr_req,
   output logic               clr_busy
);

   rf_state_t        state;
   logic [AW-1:0]    idx;
   logic [XLEN-1:0]  mem [NREG];
   logic [NREG-1:0]  sb_post;
   logic             wr_acc;
   logic             iss_acc;
   logic             seq_clr;

   assign seq_clr = (state == RF_CLEAR);
   assign wr_acc  = wb_en  && (wb_addr  != '0) && (state == RF_IDLE);
   assign iss_acc = iss_en && (iss_addr != '0) && (state == RF_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RF_IDLE;
         idx      <= AW'(1);
         clr_busy <= 1'b0;
      end else begin
         case (state)
            RF_IDLE: begin
               if (clr_req) begin
                  state    <= RF_CLEAR;
                  idx      <= AW'(1);
                  clr_busy <= 1'b1;
               end
            end
            RF_CLEAR: begin
               if (idx == AW'(NREG - 1)) begin
                  state    <= RF_IDLE;
                  idx      <= AW'(1);
                  clr_busy <= 1'b0;
               end else begin
                  idx <= idx + AW'(1);
               end
            end
            default: begin
               state    <= RF_IDLE;
               idx      <= AW'(1);
               clr_busy <= 1'b0;
            end
         endcase
      end
   end

   // Write and sequencer clear never coincide: writes are only taken in IDLE.
   // A clr_req alongside a write lets the write land; the sweep zeroes it later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else begin
         if (wr_acc)  mem[wb_addr] <= wb_data;
         if (seq_clr) mem[idx]     <= '0;
      end
   end

   rf_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .wb_clr   (wr_acc),
      .wb_addr  (wb_addr),
      .iss_set  (iss_acc),
      .iss_addr (iss_addr),
      .seq_clr  (seq_clr),
      .seq_idx  (idx),
      .sb_post  (sb_post)
   );

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data_q;
      logic            pend_q;

      assign addr = rd_addr[p*AW +: AW];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_q <= '0;
            pend_q <= 1'b0;
         end else if (rd_en[p]) begin
            if (addr == '0)
               data_q <= '0;
            else if (wr_acc && (wb_addr == addr))
               data_q <= wb_data;
            else if (seq_clr && (idx == addr))
               data_q <= '0;
            else
               data_q <= mem[addr];
            pend_q <= (addr != '0) && sb_post[addr];
         end
      end

      assign rd_data[p*XLEN +: XLEN] = data_q;
      assign rd_pend[p]              = pend_q;
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
module tb_regfile_mp_sb;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DUT A: default geometry (XLEN 32, NREG 32, NRD 2)
   logic [1:0]  rd_en_a;
   logic [9:0]  rd_addr_a;
   logic [63:0] rd_data_a;
   logic [1:0]  rd_pend_a;
   logic        wb_en_a;
   logic [4:0]  wb_addr_a;
   logic [31:0] wb_data_a;
   logic        iss_en_a;
   logic [4:0]  iss_addr_a;
   logic        clr_req_a;
   logic        clr_busy_a;

   // DUT B: XLEN 64, NREG 16, NRD 3
   logic [2:0]   rd_en_b;
   logic [11:0]  rd_addr_b;
   logic [191:0] rd_data_b;
   logic [2:0]   rd_pend_b;
   logic         wb_en_b;
   logic [3:0]   wb_addr_b;
   logic [63:0]  wb_data_b;
   logic         iss_en_b;
   logic [3:0]   iss_addr_b;
   logic         clr_req_b;
   logic         clr_busy_b;

   regfile_mp_sb u_dut_a (
      .clk(clk), .rst(rst),
      .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_pend(rd_pend_a),
      .wb_en(wb_en_a), .wb_addr(wb_addr_a), .wb_data(wb_data_a),
      .iss_en(iss_en_a), .iss_addr(iss_addr_a),
      .clr_req(clr_req_a), .clr_busy(clr_busy_a)
   );

   regfile_mp_sb #(.XLEN(64), .NREG(16), .NRD(3)) u_dut_b (
      .clk(clk), .rst(rst),
      .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_pend(rd_pend_b),
      .wb_en(wb_en_b), .wb_addr(wb_addr_b), .wb_data(wb_data_b),
      .iss_en(iss_en_b), .iss_addr(iss_addr_b),
      .clr_req(clr_req_b), .clr_busy(clr_busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      rd_en_a = '0; rd_addr_a = '0; wb_en_a = 1'b0; wb_addr_a = '0; wb_data_a = '0;
      iss_en_a = 1'b0; iss_addr_a = '0; clr_req_a = 1'b0;
   endtask

   task automatic idle_b();
      rd_en_b = '0; rd_addr_b = '0; wb_en_b = 1'b0; wb_addr_b = '0; wb_data_b = '0;
      iss_en_b = 1'b0; iss_addr_b = '0; clr_req_b = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rd_data_a, rd_pend_a, clr_busy_a} !== 67'd0) begin
         errors++; $display("FAIL reset_a got data=%h pend=%b busy=%b exp 0", rd_data_a, rd_pend_a, clr_busy_a);
      end
      checks++;
      if ({rd_data_b, rd_pend_b, clr_busy_b} !== 196'd0) begin
         errors++; $display("FAIL reset_b got data=%h pend=%b busy=%b exp 0", rd_data_b, rd_pend_b, clr_busy_b);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      wb_en_a = 1'b1; wb_addr_a = 5'd5; wb_data_a = 32'hDEADBEEF;
      tick(); idle_a();
      rd_en_a = 2'b11; rd_addr_a = {5'd0, 5'd5};
      tick(); idle_a();
      checks++;
      if (rd_data_a !== {32'h0, 32'hDEADBEEF}) begin
         errors++; $display("FAIL basic_read got %h exp %h", rd_data_a, {32'h0, 32'hDEADBEEF});
      end
   endtask

   task automatic test_bypass();
      wb_en_a = 1'b1; wb_addr_a = 5'd7; wb_data_a = 32'h1234;
      rd_en_a = 2'b11; rd_addr_a = {5'd7, 5'd7};
      tick(); idle_a();
      checks++;
      if (rd_data_a !== {32'h1234, 32'h1234}) begin
         errors++; $display("FAIL bypass got %h exp %h", rd_data_a, {32'h1234, 32'h1234});
      end
      // disabled ports hold their last value
      rd_addr_a = {5'd5, 5'd5};
      tick(); idle_a();
      checks++;
      if (rd_data_a !== {32'h1234, 32'h1234}) begin
         errors++; $display("FAIL rd_hold got %h exp %h", rd_data_a, {32'h1234, 32'h1234});
      end
   endtask

   task automatic test_scoreboard();
      iss_en_a = 1'b1; iss_addr_a = 5'd3;
      tick(); idle_a();
      rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd3};
      tick(); idle_a();
      checks++;
      if (rd_pend_a[0] !== 1'b1) begin
         errors++; $display("FAIL sb_issue got %b exp 1", rd_pend_a[0]);
      end
      wb_en_a = 1'b1; wb_addr_a = 5'd3; wb_data_a = 32'h55;
      rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd3};
      tick(); idle_a();
      checks++;
      if ({rd_pend_a[0], rd_data_a[31:0]} !== {1'b0, 32'h55}) begin
         errors++; $display("FAIL sb_wb_clear got pend=%b data=%h exp pend=0 data=00000055", rd_pend_a[0], rd_data_a[31:0]);
      end
      iss_en_a = 1'b1; iss_addr_a = 5'd3; wb_en_a = 1'b1; wb_addr_a = 5'd3; wb_data_a = 32'h66;
      tick(); idle_a();
      rd_en_a = 2'b01; rd_addr_a = {5'd0, 5'd3};
      tick(); idle_a();
      checks++;
      if ({rd_pend_a[0], rd_data_a[31:0]} !== {1'b1, 32'h66}) begin
         errors++; $display("FAIL sb_set_wins got pend=%b data=%h exp pend=1 data=00000066", rd_pend_a[0], rd_data_a[31:0]);
      end
      // a read in the issue cycle sees the bit before the set
      iss_en_a = 1'b1; iss_addr_a = 5'd12; rd_en_a = 2'b10; rd_addr_a = {5'd12, 5'd0};
      tick(); idle_a();
      checks++;
      if (rd_pend_a[1] !== 1'b0) begin
         errors++; $display("FAIL sb_same_cycle_iss got %b exp 0", rd_pend_a[1]);
      end
      rd_en_a = 2'b10; rd_addr_a = {5'd12, 5'd0};
      tick(); idle_a();
      checks++;
      if (rd_pend_a[1] !== 1'b1) begin
         errors++; $display("FAIL sb_after_iss got %b exp 1", rd_pend_a[1]);
      end
   endtask

   task automatic test_clear();
      int busy_cnt;
      for (int i = 1; i < 32; i++) begin
         wb_en_a = 1'b1; wb_addr_a = 5'(i); wb_data_a = 32'(i) * 32'h01010101;
         tick();
      end
      idle_a();
      iss_en_a = 1'b1; iss_addr_a = 5'd9;
      tick(); idle_a();
      rd_en_a = 2'b11; rd_addr_a = {5'd9, 5'd31};
      tick(); idle_a();
      checks++;
      if ({rd_pend_a, rd_data_a} !== {2'b10, 32'h09090909, 32'h1F1F1F1F}) begin
         errors++; $display("FAIL pre_clear got pend=%b data=%h exp pend=10 data=090909091f1f1f1f", rd_pend_a, rd_data_a);
      end
      clr_req_a = 1'b1;
      tick(); idle_a();
      checks++;
      if (clr_busy_a !== 1'b1) begin
         errors++; $display("FAIL clr_busy_rise got %b exp 1", clr_busy_a);
      end
      busy_cnt = (clr_busy_a === 1'b1) ? 1 : 0;
      for (int c = 1; c <= 40 && clr_busy_a === 1'b1; c++) begin
         idle_a();
         if (c == 5) begin rd_en_a = 2'b11; rd_addr_a = {5'd6, 5'd5}; end
         if (c == 20) clr_req_a = 1'b1;
         if (c == 30) begin
            wb_en_a = 1'b1; wb_addr_a = 5'd2; wb_data_a = 32'hAAAA;
            iss_en_a = 1'b1; iss_addr_a = 5'd2;
         end
         tick();
         if (clr_busy_a === 1'b1) busy_cnt++;
         if (c == 5) begin
            checks++;
            if (rd_data_a !== {32'h06060606, 32'h0}) begin
               errors++; $display("FAIL clear_bypass got %h exp 0606060600000000", rd_data_a);
            end
         end
      end
      idle_a();
      checks++;
      if (busy_cnt != 31 || clr_busy_a !== 1'b0) begin
         errors++; $display("FAIL clr_busy_len got %0d cycles busy_now=%b exp 31 cycles busy_now=0", busy_cnt, clr_busy_a);
      end
      for (int i = 1; i < 32; i++) begin
         rd_en_a = 2'b11; rd_addr_a = {5'(i), 5'(i)};
         tick();
         checks++;
         if ({rd_pend_a, rd_data_a} !== 66'd0) begin
            errors++; $display("FAIL post_clear_x%0d got pend=%b data=%h exp 0", i, rd_pend_a, rd_data_a);
         end
      end
      idle_a();
   endtask

   task automatic test_async_reset();
      wb_en_a = 1'b1; wb_addr_a = 5'd4; wb_data_a = 32'h4444;
      tick(); idle_a();
      iss_en_a = 1'b1; iss_addr_a = 5'd4;
      tick(); idle_a();
      clr_req_a = 1'b1;
      tick(); idle_a();
      for (int c = 1; c <= 9; c++) begin
         idle_a();
         if (c == 2) begin rd_en_a = 2'b11; rd_addr_a = {5'd4, 5'd4}; end
         tick();
      end
      idle_a();
      checks++;
      if ({clr_busy_a, rd_pend_a, rd_data_a} !== {1'b1, 2'b11, 32'h4444, 32'h4444}) begin
         errors++; $display("FAIL pre_rst got busy=%b pend=%b data=%h exp busy=1 pend=11 data=0000444400004444", clr_busy_a, rd_pend_a, rd_data_a);
      end
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({clr_busy_a, rd_pend_a, rd_data_a} !== 67'd0) begin
         errors++; $display("FAIL async_rst got busy=%b pend=%b data=%h exp 0", clr_busy_a, rd_pend_a, rd_data_a);
      end
      #2 rst = 1'b0;
      tick();
      wb_en_a = 1'b1; wb_addr_a = 5'd6; wb_data_a = 32'h600D;
      tick(); idle_a();
      rd_en_a = 2'b11; rd_addr_a = {5'd6, 5'd6};
      tick(); idle_a();
      checks++;
      if ({clr_busy_a, rd_data_a} !== {1'b0, 32'h600D, 32'h600D}) begin
         errors++; $display("FAIL after_rst got busy=%b data=%h exp busy=0 data=0000600d0000600d", clr_busy_a, rd_data_a);
      end
   endtask

   task automatic test_x0();
      wb_en_a = 1'b1; wb_addr_a = 5'd0; wb_data_a = 32'hFFFFFFFF;
      iss_en_a = 1'b1; iss_addr_a = 5'd0;
      tick(); idle_a();
      rd_en_a = 2'b11; rd_addr_a = {5'd0, 5'd0};
      tick(); idle_a();
      checks++;
      if ({rd_pend_a, rd_data_a} !== 66'd0) begin
         errors++; $display("FAIL x0_a got pend=%b data=%h exp 0", rd_pend_a, rd_data_a);
      end
   endtask

   task automatic test_wide();
      int busy_cnt;
      wb_en_b = 1'b1; wb_addr_b = 4'd15; wb_data_b = 64'h0123456789ABCDEF;
      tick(); idle_b();
      wb_en_b = 1'b1; wb_addr_b = 4'd0; wb_data_b = '1;
      iss_en_b = 1'b1; iss_addr_b = 4'd0;
      tick(); idle_b();
      iss_en_b = 1'b1; iss_addr_b = 4'd15;
      tick(); idle_b();
      rd_en_b = 3'b111; rd_addr_b = {4'd15, 4'd0, 4'd15};
      tick(); idle_b();
      checks++;
      if ({rd_pend_b, rd_data_b} !== {3'b101, 64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF}) begin
         errors++; $display("FAIL wide_read got pend=%b data=%h", rd_pend_b, rd_data_b);
      end
      // write and clear request together: the clear wins in the end
      wb_en_b = 1'b1; wb_addr_b = 4'd5; wb_data_b = 64'hABCD;
      clr_req_b = 1'b1;
      tick(); idle_b();
      busy_cnt = 0;
      for (int c = 0; c < 30 && clr_busy_b === 1'b1; c++) begin
         busy_cnt++;
         tick();
      end
      checks++;
      if (busy_cnt != 15 || clr_busy_b !== 1'b0) begin
         errors++; $display("FAIL wide_busy_len got %0d busy_now=%b exp 15 busy_now=0", busy_cnt, clr_busy_b);
      end
      rd_en_b = 3'b111; rd_addr_b = {4'd5, 4'd0, 4'd15};
      tick(); idle_b();
      checks++;
      if ({rd_pend_b, rd_data_b} !== 195'd0) begin
         errors++; $display("FAIL wide_post_clear got pend=%b data=%h exp 0", rd_pend_b, rd_data_b);
      end
   endtask

   initial begin
      idle_a();
      idle_b();
      test_reset();
      test_basic();
      test_bypass();
      test_scoreboard();
      test_clear();
      test_async_reset();
      test_x0();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got no finish exp finish before 200000");
      $fatal(1);
   end

endmodule
